// File: rtl/pingpong_weight_memory.sv
// rtl/pingpong_weight_memory.sv - double-buffered (ping/pong) weight store between weight stream and PE array
//
// One set is filled from the weight stream while the compute engine reads the
// other; sets swap under a full/release handshake.
//
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   s_axis_tdata      weight beat (one bank word)
//   s_axis_tvalid     beat valid
//   s_axis_tlast      last beat of the current line buffer
//   s_axis_tready     beat accepted when tvalid & tready
//   i_addr_offset     offset added (mod DEPTH) to every read address
//   i_rd_en           read request, all line buffers in parallel
//   i_rd_addr         packed per-line-buffer read addresses
//   o_rd_data         packed read data, all banks of all line buffers
//   o_rd_valid        o_rd_data valid, READ_LATENCY cycles after i_rd_en
//   o_weights_ready   read set is full
//   i_release         compute finished with the read set
//   o_overflow        sticky: a beat beyond DEPTH was dropped
module pingpong_weight_memory #(
  parameter int BANK_BIT_WIDTH = 8,
  parameter int BANK_COUNT     = 8,
  parameter int LINE_BUFFERS   = 3,
  parameter int DEPTH          = 512,
  parameter int READ_LATENCY   = 2,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  logic [BANK_BIT_WIDTH-1:0]                     s_axis_tdata,
  input  logic                                          s_axis_tvalid,
  input  logic                                          s_axis_tlast,
  output logic                                          s_axis_tready,
  input  logic [AW-1:0]                                 i_addr_offset,
  input  logic                                          i_rd_en,
  input  logic [LINE_BUFFERS*AW-1:0]                    i_rd_addr,
  output logic [LINE_BUFFERS*BANK_COUNT*BANK_BIT_WIDTH-1:0] o_rd_data,
  output logic                                          o_rd_valid,
  output logic                                          o_weights_ready,
  input  logic                                          i_release,
  output logic                                          o_overflow
);

  localparam int BPW = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
  localparam int LPW = (LINE_BUFFERS > 1) ? $clog2(LINE_BUFFERS) : 1;
  localparam int LW  = BANK_COUNT * BANK_BIT_WIDTH;
  localparam int DW  = LINE_BUFFERS * LW;

  typedef enum logic {
    W_FILL = 1'b0,
    W_WAIT = 1'b1
  } wstate_t;

  wstate_t        state, state_nxt;
  logic [BPW-1:0] bank_ptr, bank_ptr_nxt;
  // One extra bit: wr_addr saturates at DEPTH, which marks "past the end".
  logic [AW:0]    wr_addr, wr_addr_nxt;
  logic [LPW-1:0] lb_ptr, lb_ptr_nxt;
  logic           wr_set, wr_set_nxt;
  logic           rd_set, rd_set_nxt;
  logic [1:0]     full, full_nxt;
  logic           overflow, overflow_nxt;

  logic beat;
  logic wr_en;
  logic set_done;
  logic release_ok;

  assign s_axis_tready   = (state == W_FILL);
  assign beat            = s_axis_tvalid & s_axis_tready;
  assign wr_en           = beat & ~wr_addr[AW] & resetn;
  assign set_done        = beat & s_axis_tlast & (lb_ptr == LPW'(LINE_BUFFERS - 1));
  assign release_ok      = i_release & full[rd_set];
  assign o_weights_ready = full[rd_set];
  assign o_overflow      = overflow;

  // ---------------------------------------------------------------------------
  // Write FSM and set bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= W_FILL;
      bank_ptr <= '0;
      wr_addr  <= '0;
      lb_ptr   <= '0;
      wr_set   <= 1'b0;
      rd_set   <= 1'b0;
      full     <= 2'b00;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      bank_ptr <= bank_ptr_nxt;
      wr_addr  <= wr_addr_nxt;
      lb_ptr   <= lb_ptr_nxt;
      wr_set   <= wr_set_nxt;
      rd_set   <= rd_set_nxt;
      full     <= full_nxt;
      overflow <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bank_ptr_nxt = bank_ptr;
    wr_addr_nxt  = wr_addr;
    lb_ptr_nxt   = lb_ptr;
    wr_set_nxt   = wr_set;
    overflow_nxt = overflow;

    // Release and completion always target different sets, so both apply.
    full_nxt = full;
    if (release_ok) full_nxt[rd_set] = 1'b0;
    if (set_done)   full_nxt[wr_set] = 1'b1;
    rd_set_nxt = rd_set ^ release_ok;

    if (beat && wr_addr[AW]) overflow_nxt = 1'b1;

    case (state)
      W_FILL: begin
        if (beat) begin
          if (s_axis_tlast) begin
            bank_ptr_nxt = '0;
            wr_addr_nxt  = '0;
            if (set_done) begin
              lb_ptr_nxt = '0;
              wr_set_nxt = ~wr_set;
            end else begin
              lb_ptr_nxt = lb_ptr + 1'b1;
            end
            // Look at the post-release flag so a release in the same cycle
            // as the final beat does not cost a stall cycle.
            state_nxt = full_nxt[wr_set_nxt] ? W_WAIT : W_FILL;
          end else if (bank_ptr == BPW'(BANK_COUNT - 1)) begin
            bank_ptr_nxt = '0;
            if (!wr_addr[AW]) wr_addr_nxt = wr_addr + 1'b1;
          end else begin
            bank_ptr_nxt = bank_ptr + 1'b1;
          end
        end
      end
      W_WAIT: begin
        if (!full[wr_set]) state_nxt = W_FILL;
      end
      default: state_nxt = W_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bank RAMs: one per (line buffer, bank); the set bit is the address MSB.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ram_q;
  logic          ram_v;

  for (genvar lb = 0; lb < LINE_BUFFERS; lb++) begin : g_lb
    logic [AW-1:0] raddr;
    assign raddr = i_rd_addr[lb*AW +: AW] + i_addr_offset;

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
      logic [BANK_BIT_WIDTH-1:0] mem [2*DEPTH];
      logic [BANK_BIT_WIDTH-1:0] q;

      always_ff @(posedge clk) begin
        if (wr_en && (lb_ptr == LPW'(lb)) && (bank_ptr == BPW'(b))) begin
          mem[{wr_set, wr_addr[AW-1:0]}] <= s_axis_tdata;
        end
      end

      // rd_set is sampled here, so in-flight reads finish from the old set.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          q <= '0;
        end else if (i_rd_en) begin
          q <= mem[{rd_set, raddr}];
        end
      end

      assign ram_q[(lb*BANK_COUNT+b)*BANK_BIT_WIDTH +: BANK_BIT_WIDTH] = q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) ram_v <= 1'b0;
    else         ram_v <= i_rd_en;
  end

  // ---------------------------------------------------------------------------
  // Output register stages; each stage only loads on valid so the data
  // output holds its last value between reads.
  // ---------------------------------------------------------------------------
  if (READ_LATENCY == 1) begin : g_lat1
    assign o_rd_valid = ram_v;
    assign o_rd_data  = ram_q;
  end else begin : g_latn
    logic [DW-1:0]            pd [READ_LATENCY-1];
    logic [READ_LATENCY-2:0]  pv;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        pv <= '0;
        for (int k = 0; k < READ_LATENCY - 1; k++) pd[k] <= '0;
      end else begin
        pv[0] <= ram_v;
        if (ram_v) pd[0] <= ram_q;
        for (int k = 1; k < READ_LATENCY - 1; k++) begin
          pv[k] <= pv[k-1];
          if (pv[k-1]) pd[k] <= pd[k-1];
        end
      end
    end

    assign o_rd_valid = pv[READ_LATENCY-2];
    assign o_rd_data  = pd[READ_LATENCY-2];
  end

endmodule

// File: tb/tb_pingpong_weight_memory.sv
// tb/tb_pingpong_weight_memory.sv - randomized self-checking bench for pingpong_weight_memory
module tb_pingpong_weight_memory;

  localparam int W  = 8;
  localparam int BC = 8;
  localparam int LB = 3;
  localparam int D  = 512;
  localparam int AW = 9;
  localparam int L  = 2;
  localparam int LW = BC * W;
  localparam int DW = LB * LW;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [W-1:0]      s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic [AW-1:0]     i_addr_offset = '0;
  logic              i_rd_en = 1'b0;
  logic [LB*AW-1:0]  i_rd_addr = '0;
  logic [DW-1:0]     o_rd_data;
  logic              o_rd_valid;
  logic              o_weights_ready;
  logic              i_release = 1'b0;
  logic              o_overflow;

  pingpong_weight_memory #(
    .BANK_BIT_WIDTH(W), .BANK_COUNT(BC), .LINE_BUFFERS(LB), .DEPTH(D), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .i_addr_offset(i_addr_offset), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_weights_ready(o_weights_ready), .i_release(i_release), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [LW-1:0] mm [2][LB][D];
  bit   [BC-1:0] mw [2][LB][D];
  bit            m_full [2];
  bit            m_wr_set, m_rd_set, m_ready, m_ovf, started;
  int            m_n, m_lb, cyc;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
    bit            ok;
  } rd_t;
  rd_t           rq[$];
  logic [DW-1:0] last_d;
  bit            last_known;

  always @(posedge clk) begin
    rd_t e;
    bit  acc, rel, done;
    bit  nf [2];
    int  a;
    cyc++;
    if (!resetn) begin
      m_full[0] = 0; m_full[1] = 0;
      m_wr_set = 0; m_rd_set = 0; m_ready = 1; m_ovf = 0;
      m_n = 0; m_lb = 0;
      rq.delete();
      last_d = '0; last_known = 1; started = 1;
    end else begin
      acc = s_axis_tvalid && m_ready;
      rel = i_release && m_full[m_rd_set];
      if (i_rd_en) begin
        e.due = cyc + L - 1;
        e.ok  = m_full[m_rd_set];
        for (int i = 0; i < LB; i++) begin
          a = (int'(i_rd_addr[i*AW +: AW]) + int'(i_addr_offset)) % D;
          e.d[i*LW +: LW] = mm[m_rd_set][i][a];
          if (mw[m_rd_set][i][a] != '1) e.ok = 0;
        end
        rq.push_back(e);
      end
      done = 0;
      if (acc) begin
        if (m_n / BC < D) begin
          mm[m_wr_set][m_lb][m_n/BC][(m_n%BC)*W +: W] = s_axis_tdata;
          mw[m_wr_set][m_lb][m_n/BC][m_n%BC] = 1'b1;
        end else begin
          m_ovf = 1;
        end
        m_n++;
        if (s_axis_tlast) begin
          m_n = 0;
          if (m_lb == LB - 1) begin m_lb = 0; done = 1; end
          else m_lb++;
        end
      end
      nf = m_full;
      if (rel) nf[m_rd_set] = 0;
      if (done) begin nf[m_wr_set] = 1; m_wr_set = !m_wr_set; end
      if (acc && s_axis_tlast) m_ready = !nf[m_wr_set];
      else if (!m_ready) m_ready = !m_full[m_wr_set];
      if (rel) m_rd_set = !m_rd_set;
      m_full = nf;
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (started) begin
      chk("tready", {{(DW-1){1'b0}}, s_axis_tready}, {{(DW-1){1'b0}}, m_ready});
      chk("weights_ready", {{(DW-1){1'b0}}, o_weights_ready}, {{(DW-1){1'b0}}, m_full[m_rd_set]});
      chk("overflow", {{(DW-1){1'b0}}, o_overflow}, {{(DW-1){1'b0}}, m_ovf});
      ev = (rq.size() > 0) && (rq[0].due == cyc);
      chk("rd_valid", {{(DW-1){1'b0}}, o_rd_valid}, {{(DW-1){1'b0}}, ev});
      if (ev) begin
        last_d = rq[0].d;
        last_known = rq[0].ok;
        void'(rq.pop_front());
      end
      if (last_known) chk("rd_data", o_rd_data, last_d);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_lb(input int n, input int lb, input int mode, input int gap, input bit rel_last);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
      case (mode)
        0:       s_axis_tdata = W'($urandom);
        1:       s_axis_tdata = W'(lb * n + i + 1);
        default: s_axis_tdata = W'({lb[1:0], 6'(i / BC)});
      endcase
      s_axis_tlast  = (i == n - 1);
      s_axis_tvalid = 1'b1;
      if (rel_last && i == n - 1) i_release = 1'b1;
      while (!m_ready && g < 3000) begin @(negedge clk); g++; end
      if (g >= 3000) begin
        checks++; errors++;
        $display("FAIL tready_wait: got no ready within 3000 cycles, required ready");
      end
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (rel_last) i_release = 1'b0;
    end
  endtask

  task automatic fill_set(input int mode, input int n, input int gap, input bit rel_last);
    for (int lb = 0; lb < LB; lb++) send_lb(n, lb, mode, gap, rel_last && lb == LB - 1);
  endtask

  task automatic pulse_release();
    i_release = 1'b1;
    @(negedge clk);
    i_release = 1'b0;
  endtask

  // Random reads aimed at words 0..maxa of each line buffer, through a random offset.
  task automatic set_rand_read(input int maxa);
    int off;
    off = $urandom_range(0, D - 1);
    i_addr_offset = AW'(off);
    for (int l = 0; l < LB; l++) i_rd_addr[l*AW +: AW] = AW'($urandom_range(0, maxa) - off);
  endtask

  task automatic rand_reads(input int n, input int maxa);
    for (int i = 0; i < n; i++) begin
      i_rd_en = ($urandom_range(0, 3) != 0);
      set_rand_read(maxa);
      @(negedge clk);
    end
    i_rd_en = 1'b0;
    repeat (L + 1) @(negedge clk);
  endtask

  logic [DW-1:0] lit0, lit1, lit_off;
  bit            wdone;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    lit0    = {64'h2827262524232221, 64'h1817161514131211, 64'h0807060504030201};
    lit1    = {64'h302F2E2D2C2B2A29, 64'h201F1E1D1C1B1A19, 64'h100F0E0D0C0B0A09};
    lit_off = {64'h8888888888888888, 64'h4848484848484848, 64'h0808080808080808};

    // reset values
    repeat (3) @(negedge clk);
    chk("reset_tready", {{(DW-1){1'b0}}, s_axis_tready}, 1);
    chk("reset_weights_ready", {{(DW-1){1'b0}}, o_weights_ready}, 0);
    chk("reset_rd_valid", {{(DW-1){1'b0}}, o_rd_valid}, 0);
    chk("reset_rd_data", o_rd_data, 0);
    chk("reset_overflow", {{(DW-1){1'b0}}, o_overflow}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // basic fill of PING and read of words 0/1
    fill_set(1, 16, 0, 0);
    chk("ready_after_fill", {{(DW-1){1'b0}}, o_weights_ready}, 1);
    i_addr_offset = '0;
    i_rd_addr = '0;
    i_rd_en = 1'b1;
    @(negedge clk);
    i_rd_addr = {LB{AW'(1)}};
    @(negedge clk);
    i_rd_en = 1'b0;
    chk("lit_valid0", {{(DW-1){1'b0}}, o_rd_valid}, 1);
    chk("lit_word0", o_rd_data, lit0);
    @(negedge clk);
    chk("lit_word1", o_rd_data, lit1);
    @(negedge clk);
    chk("lit_valid_end", {{(DW-1){1'b0}}, o_rd_valid}, 0);
    chk("lit_hold", o_rd_data, lit1);

    // fill PONG with no release: stream stalls
    fill_set(0, 16, 0, 0);
    chk("stall_tready", {{(DW-1){1'b0}}, s_axis_tready}, 0);
    pulse_release();
    chk("swap_weights_ready", {{(DW-1){1'b0}}, o_weights_ready}, 1);
    @(negedge clk);
    chk("resume_tready", {{(DW-1){1'b0}}, s_axis_tready}, 1);
    rand_reads(40, 1);

    // offset wrap: 500 + 20 -> word 8
    fill_set(2, 168, 2, 0);
    pulse_release();
    i_addr_offset = AW'(500);
    i_rd_addr = {LB{AW'(20)}};
    i_rd_en = 1'b1;
    @(negedge clk);
    i_rd_en = 1'b0;
    @(negedge clk);
    chk("lit_offset_wrap", o_rd_data, lit_off);
    rand_reads(60, 20);

    // release and final tlast of the other set in the same cycle
    fill_set(0, 16, 0, 1);
    chk("same_cycle_tready", {{(DW-1){1'b0}}, s_axis_tready}, 1);
    chk("same_cycle_ready", {{(DW-1){1'b0}}, o_weights_ready}, 1);
    rand_reads(40, 1);

    // overflow on line buffer 0 of PING
    chk("pre_overflow", {{(DW-1){1'b0}}, o_overflow}, 0);
    send_lb(D * BC + 2, 0, 0, 0, 0);
    send_lb(16, 1, 0, 0, 0);
    send_lb(16, 2, 0, 0, 0);
    chk("overflow_set", {{(DW-1){1'b0}}, o_overflow}, 1);
    pulse_release();
    i_addr_offset = '0;
    i_rd_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i_rd_addr = {AW'(k % 2), AW'(1 - k % 2), AW'((k < 3) ? k : D - 6 + k)};
      @(negedge clk);
    end
    i_rd_en = 1'b0;
    repeat (L + 1) @(negedge clk);
    rand_reads(40, 1);

    // random concurrent fill/read/release traffic
    wdone = 0;
    fork
      begin
        repeat (4)
          for (int lb = 0; lb < LB; lb++) send_lb($urandom_range(1, 40), lb, 0, 3, 0);
        wdone = 1;
      end
      begin
        int t0;
        t0 = cyc;
        while (!wdone && (cyc - t0) < 20000) begin
          i_rd_en = $urandom_range(0, 1);
          set_rand_read(4);
          i_release = ($urandom_range(0, 11) == 0);
          @(negedge clk);
        end
        i_rd_en = 1'b0;
        i_release = 1'b0;
      end
    join
    repeat (L + 1) @(negedge clk);
    chk("overflow_sticky", {{(DW-1){1'b0}}, o_overflow}, 1);

    // reset mid-fill and mid-read
    i_release = 1'b1;
    repeat (2) @(negedge clk);
    i_release = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = W'($urandom);
      i_rd_en = 1'b1;
      set_rand_read(4);
      @(negedge clk);
    end
    resetn = 1'b0;
    s_axis_tvalid = 1'b0;
    i_rd_en = 1'b0;
    @(negedge clk);
    chk("midreset_tready", {{(DW-1){1'b0}}, s_axis_tready}, 1);
    chk("midreset_weights_ready", {{(DW-1){1'b0}}, o_weights_ready}, 0);
    chk("midreset_rd_valid", {{(DW-1){1'b0}}, o_rd_valid}, 0);
    chk("midreset_rd_data", o_rd_data, 0);
    chk("midreset_overflow", {{(DW-1){1'b0}}, o_overflow}, 0);
    resetn = 1'b1;
    @(negedge clk);
    fill_set(1, 16, 0, 0);
    chk("refill_ready", {{(DW-1){1'b0}}, o_weights_ready}, 1);
    i_addr_offset = '0;
    i_rd_addr = '0;
    i_rd_en = 1'b1;
    @(negedge clk);
    i_rd_en = 1'b0;
    @(negedge clk);
    chk("refill_word0", o_rd_data, lit0);
    rand_reads(30, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
